ik_iter_ctrl: RTL
=================

// Module: ik_iter_ctrl
// PURPOSE
//  Iteration sequencer for the ik_swift solver core. It loads joint angles, runs one solver pass, adds the
//  returned joint deltas into the angles, and tests for convergence. It repeats until converged, until
//  max_iter passes have run, or until abort/watchdog. Sits between the Avalon register slave and ik_swift.
// PARAMETERS
//  NJ        6         number of joints (delta/theta lanes)
//  W         36        datapath width, signed fixed point, 65536 = 1.0
//  WDOG      4096      max cycles to wait for core_done per pass before error
// PORTS
//  clk         in   1          clock
//  reset       in   1          synchronous, active-high reset
//  start       in   1          1-cycle pulse; begin a solve (ignored while busy)
//  abort       in   1          level; terminate current solve
//  max_iter    in   16         pass limit, sampled on start (0 treated as 1)
//  threshold   in   W          convergence bound on |delta|, unsigned, sampled on start
//  theta_init  in   NJ*W       initial joint angles, sampled on start
//  core_en     out  1          solver enable (ifc_ik_swift.en)
//  core_done   in   1          solver pass complete (ifc_ik_swift.done), level
//  core_delta  in   NJ*W       per-joint signed delta from solver, valid while core_done=1
//  theta       out  NJ*W       current joint angles (feeds dh_param_in THETA fields)
//  busy        out  1          solve in progress
//  done        out  1          1-cycle pulse at solve end
//  converged   out  1          sticky result flag, cleared on start
//  iter_count  out  16         passes completed in current/last solve
//  wdog_err    out  1          sticky: watchdog expired, cleared on start
// BEHAVIOUR
//  Reset: state=IDLE; core_en, busy, done, converged, wdog_err = 0; iter_count = 0; theta = 0.
//  IDLE  : start & ~abort -> LOAD. Latch theta<=theta_init, max_iter, threshold; clear iter_count/flags.
//  LOAD  : 1 cycle; theta is stable on the solver inputs -> RUN.
//  RUN   : core_en=1, watchdog counter=0 -> WAIT.
//  WAIT  : core_en=1; count cycles. core_done -> UPDATE, capture core_delta same cycle.
//          Counter reaches WDOG -> wdog_err=1 -> FINISH.
//  UPDATE: theta[i] <= sat(theta[i]+delta[i]) (W+1-bit sum, clamp to +/-(2^(W-1)-1) / -2^(W-1));
//          iter_count++; conv = AND over i of |delta[i]| <= threshold (|-2^(W-1)| = 2^(W-1)-1).
//  CHECK : conv -> converged=1 -> FINISH; else iter_count==max_iter -> FINISH; else -> GAP.
//  GAP   : core_en=0 for exactly 1 cycle (the solver re-arms only on an en low->high edge) -> RUN.
//  FINISH: core_en=0, done=1 for 1 cycle -> IDLE. busy=1 in every state except IDLE.
//  Latency: each pass = solver latency + 4 cycles of overhead (RUN, UPDATE, CHECK, GAP).
//  abort: in any non-IDLE state -> FINISH next cycle. theta keeps the last committed value.
//         converged stays 0. abort has priority over core_done and the watchdog in the same cycle.
//  start while busy: ignored. start and abort together in IDLE: abort wins, no solve.
//  core_done outside WAIT: ignored. Reset mid-solve: all state returns to reset values immediately.
//  iter_count saturates at 16'hFFFF (only reachable with max_iter=FFFF).
// CONFIGURATION
//  IK_ITER_WRAP_EN defined: after the saturating add, wrap each theta into [-PI, PI]
//    (PI = 205887, 2PI = 411775). One conditional add/sub of 2PI, same UPDATE cycle.
//  Not defined: plain saturating accumulate, no wrap; theta may exceed +/-PI.
// TESTING
//  1 reset; start with theta_init=0, max_iter=5, threshold=655; model returns delta=65536 on all lanes
//    -> 5 passes, theta[i]=327680, iter_count=5, converged=0, one done pulse.
//  2 model deltas 6553 then 100 (all lanes), threshold=655 -> converged=1, iter_count=2,
//    theta[i]=6653 + theta_init.
//  3 core_done never asserts -> wdog_err=1 after WDOG cycles in WAIT; core_en=0; done pulse; busy falls.
//  4 abort asserted in WAIT on the same cycle as core_done -> no UPDATE, theta unchanged;
//    done pulse next cycle; converged=0.
//  5 theta_init=2^35-10, delta=+100 -> theta clamps to 2^35-1. With IK_ITER_WRAP_EN:
//    theta_init=200000, delta=10000 -> theta = -201775.
//  6 start pulsed while busy and reset pulsed mid-WAIT -> start ignored;
//    after reset all outputs are 0 and state is IDLE.

Source files
------------

// File: rtl/ik_iter_ctrl.sv
// ik_iter_ctrl: iteration sequencer around the ik_swift solver core.
// Define IK_ITER_WRAP_EN to wrap each committed theta into [-PI, PI].
module ik_iter_ctrl #(
   parameter int NJ   = 6,
   parameter int W    = 36,
   parameter int WDOG = 4096
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            start,
   input  logic            abort,
   input  logic [15:0]     max_iter,
   input  logic [W-1:0]    threshold,
   input  logic [NJ*W-1:0] theta_init,
   output logic            core_en,
   input  logic            core_done,
   input  logic [NJ*W-1:0] core_delta,
   output logic [NJ*W-1:0] theta,
   output logic            busy,
   output logic            done,
   output logic            converged,
   output logic [15:0]     iter_count,
   output logic            wdog_err
);

   localparam logic signed [W-1:0] SMAX = {1'b0, {(W-1){1'b1}}};
   localparam logic signed [W-1:0] SMIN = {1'b1, {(W-1){1'b0}}};
   localparam int WDW = $clog2(WDOG + 1);
   localparam logic [WDW-1:0] WDOG_LAST = WDW'(WDOG - 1);
`ifdef IK_ITER_WRAP_EN
   localparam logic signed [W-1:0] PI     = W'(205887);
   localparam logic signed [W-1:0] TWO_PI = W'(411775);
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_RUN,
      S_WAIT,
      S_UPDATE,
      S_CHECK,
      S_GAP,
      S_FINISH
   } state_t;

   state_t state;

   logic signed [W-1:0] th    [NJ];
   logic signed [W-1:0] dlt   [NJ];
   logic signed [W-1:0] th_nx [NJ];
   logic [15:0]         mi;
   logic [W-1:0]        thr;
   logic [WDW-1:0]      wcnt;
   logic                conv;
   logic                conv_nx;

   function automatic logic signed [W-1:0] sat_add(
      input logic signed [W-1:0] a,
      input logic signed [W-1:0] b
   );
      logic signed [W:0]   s;
      logic signed [W-1:0] r;
      s = {a[W-1], a} + {b[W-1], b};
      if (s[W] != s[W-1])
         r = s[W] ? SMIN : SMAX;
      else
         r = s[W-1:0];
`ifdef IK_ITER_WRAP_EN
      if (r > PI)
         r = r - TWO_PI;
      else if (r < -PI)
         r = r + TWO_PI;
`endif
      return r;
   endfunction

   // The most negative delta has no positive twin; treat it as SMAX.
   function automatic logic [W-1:0] mag(input logic signed [W-1:0] d);
      logic [W-1:0] m;
      if (d == SMIN)
         m = SMAX;
      else if (d[W-1])
         m = -d;
      else
         m = d;
      return m;
   endfunction

   always_comb begin
      conv_nx = 1'b1;
      for (int i = 0; i < NJ; i++) begin
         th_nx[i] = sat_add(th[i], dlt[i]);
         if (mag(dlt[i]) > thr)
            conv_nx = 1'b0;
      end
   end

   for (genvar g = 0; g < NJ; g++) begin : g_out
      assign theta[g*W +: W] = th[g];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= S_IDLE;
         core_en    <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
         converged  <= 1'b0;
         wdog_err   <= 1'b0;
         iter_count <= '0;
         mi         <= '0;
         thr        <= '0;
         wcnt       <= '0;
         conv       <= 1'b0;
         for (int i = 0; i < NJ; i++) begin
            th[i]  <= '0;
            dlt[i] <= '0;
         end
      end else begin
         done <= 1'b0;
         if (abort && state != S_IDLE && state != S_FINISH) begin
            state   <= S_FINISH;
            core_en <= 1'b0;
            done    <= 1'b1;
         end else begin
            unique case (state)
               S_IDLE: begin
                  if (start && !abort) begin
                     state      <= S_LOAD;
                     busy       <= 1'b1;
                     mi         <= (max_iter == 16'd0) ? 16'd1 : max_iter;
                     thr        <= threshold;
                     iter_count <= '0;
                     converged  <= 1'b0;
                     wdog_err   <= 1'b0;
                     for (int i = 0; i < NJ; i++)
                        th[i] <= theta_init[i*W +: W];
                  end
               end
               S_LOAD: begin
                  state   <= S_RUN;
                  core_en <= 1'b1;
               end
               S_RUN: begin
                  state <= S_WAIT;
                  wcnt  <= '0;
               end
               S_WAIT: begin
                  if (core_done) begin
                     state <= S_UPDATE;
                     for (int i = 0; i < NJ; i++)
                        dlt[i] <= core_delta[i*W +: W];
                  end else if (wcnt == WDOG_LAST) begin
                     state    <= S_FINISH;
                     wdog_err <= 1'b1;
                     core_en  <= 1'b0;
                     done     <= 1'b1;
                  end else begin
                     wcnt <= wcnt + 1'b1;
                  end
               end
               S_UPDATE: begin
                  state <= S_CHECK;
                  conv  <= conv_nx;
                  for (int i = 0; i < NJ; i++)
                     th[i] <= th_nx[i];
                  if (iter_count != 16'hFFFF)
                     iter_count <= iter_count + 16'd1;
               end
               S_CHECK: begin
                  if (conv || iter_count == mi) begin
                     state     <= S_FINISH;
                     converged <= conv;
                     core_en   <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     state   <= S_GAP;
                     core_en <= 1'b0;
                  end
               end
               // Solver re-arms only on a rising edge of core_en.
               S_GAP: begin
                  state   <= S_RUN;
                  core_en <= 1'b1;
               end
               S_FINISH: begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
               default: begin
                  state   <= S_IDLE;
                  core_en <= 1'b0;
                  busy    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
